affine_solve_seq: RTL and testbench

Sequential inverse of the combinational fixed-point multiply-accumulate: given y, m and b in a signed fixed-point format, it solves y = m·x + b for x = (y − b) / m. It uses a one-bit-per-cycle restoring divider with valid/ready handshakes on both sides. It sits downstream of MAC stages in the mlops datapath, wherever a gain/offset must be undone, such as normalisation and calibration inversion.

---
 rtl/sfp_pkg.sv | 25 ++
 rtl/affine_solve_seq_if.sv | 25 ++
 rtl/sfp_div_core.sv | 72 +++++++
 rtl/affine_solve_seq.sv | 217 +++++++++++++++++++++
 tb/tb_affine_solve_seq.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/sfp_pkg.sv
// Shared definitions for the signed fixed-point (sfp) block family:
// controller states, saturation limits and divider iteration count.
package sfp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // One iteration per numerator bit: |diff| is W+1 bits, pre-shifted by QW.
    function automatic int sfp_nb(input int iw, input int qw);
        return iw + qw + qw + 32'sd1;
    endfunction

    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 32'sd1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 32'sd1));
    endfunction

endpackage

// File: rtl/affine_solve_seq_if.sv
// Operand/result handshake bundle for affine_solve_seq.
interface affine_solve_seq_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] y;
    logic [W-1:0] m;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] x;
    logic         sat;
    logic         dz;

    modport master (
        output in_valid, y, m, b, out_ready,
        input  in_ready, out_valid, x, sat, dz
    );

    modport slave (
        input  in_valid, y, m, b, out_ready,
        output in_ready, out_valid, x, sat, dz
    );
endinterface

// File: rtl/sfp_div_core.sv
// Unsigned restoring divider, one quotient bit per cycle, numerator MSB first.
// done is high during the final iteration; q then carries the finished quotient.
module sfp_div_core #(
    parameter int NW = 25,
    parameter int DW = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [NW-1:0] n,
    input  logic [DW-1:0] d,
    output logic          done,
    output logic [NW-1:0] q
);

    localparam int CW = $clog2(NW + 1);

    logic [NW-1:0] n_r;
    logic [DW-1:0] d_r;
    logic [DW-1:0] r_r;
    logic [NW-1:0] q_r;
    logic [CW-1:0] cnt_r;
    logic          busy_r;

    logic [DW:0]   r_sh_s;
    logic [DW:0]   r_diff_s;
    logic          ge_s;
    logic [DW-1:0] r_nx_s;
    logic [NW-1:0] q_nx_s;

    // One restoring step; the remainder always stays below d, so DW bits hold it.
    always_comb begin
        r_sh_s   = {r_r, n_r[NW-1]};
        r_diff_s = r_sh_s - {1'b0, d_r};
        ge_s     = (r_sh_s >= {1'b0, d_r});
        if (ge_s) begin
            r_nx_s = r_diff_s[DW-1:0];
        end else begin
            r_nx_s = r_sh_s[DW-1:0];
        end
        q_nx_s = {q_r[NW-2:0], ge_s};
    end

    assign done = busy_r && (cnt_r == CW'(1));
    assign q    = q_nx_s;

    // Operand load on start, then shift/subtract until the counter runs out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_r    <= {NW{1'b0}};
            d_r    <= {DW{1'b0}};
            r_r    <= {DW{1'b0}};
            q_r    <= {NW{1'b0}};
            cnt_r  <= {CW{1'b0}};
            busy_r <= 1'b0;
        end else if (start) begin
            n_r    <= n;
            d_r    <= d;
            r_r    <= {DW{1'b0}};
            q_r    <= {NW{1'b0}};
            cnt_r  <= CW'(NW);
            busy_r <= 1'b1;
        end else if (busy_r) begin
            n_r    <= {n_r[NW-2:0], 1'b0};
            r_r    <= r_nx_s;
            q_r    <= q_nx_s;
            cnt_r  <= cnt_r - CW'(1);
            busy_r <= (cnt_r != CW'(1));
        end
    end

endmodule

// File: rtl/affine_solve_seq.sv
// Solves y = m*x + b for x in signed Q(IW.QW): sign/magnitude split around
// an unsigned restoring divider, with zero-gain handling and saturation.
module affine_solve_seq
    import sfp_pkg::*;
#(
    parameter int IW = 8,
    parameter int QW = 8
) (
    input  logic                clk_in,
    input  logic                rst_in,
    affine_solve_seq_if.slave   io
);

    localparam int W  = IW + QW;
    localparam int NB = sfp_nb(IW, QW);
    localparam int DW = W + 1;

    localparam logic [W-1:0]  SAT_MAX_X = W'(sat_max(W));
    localparam logic [W-1:0]  SAT_MIN_X = W'(sat_min(W));
    localparam logic [NB-1:0] POS_LIM   = NB'(sat_max(W));
    localparam logic [NB-1:0] NEG_LIM   = NB'(-sat_min(W));

    state_t state_r;
    state_t state_nx_s;

    logic [W-1:0] y_r;
    logic [W-1:0] m_r;
    logic [W-1:0] b_r;
    logic         neg_r;
    logic         dz_pend_r;
    logic         dsign_r;
    logic         dzero_r;
    logic [W-1:0] x_r;
    logic         sat_r;
    logic         dz_r;
    logic         out_valid_r;

    logic          accept_s;
    logic          start_s;
    logic          finish_s;
    logic          consume_s;
    logic [W:0]    diff_s;
    logic [W:0]    adiff_s;
    logic [W:0]    m_ext_s;
    logic [DW-1:0] d_s;
    logic [NB-1:0] n_s;
    logic          m_zero_s;
    logic          core_done_s;
    logic [NB-1:0] q_s;
    logic [NB-1:0] q_neg_s;
    logic [W-1:0]  fin_x_s;
    logic          fin_sat_s;

    // Operand conditioning: exact W+1 bit difference and magnitudes for the divider.
    always_comb begin
        diff_s   = {y_r[W-1], y_r} - {b_r[W-1], b_r};
        m_ext_s  = {m_r[W-1], m_r};
        m_zero_s = (m_r == {W{1'b0}});
        if (diff_s[W]) begin
            adiff_s = -diff_s;
        end else begin
            adiff_s = diff_s;
        end
        if (m_r[W-1]) begin
            d_s = -m_ext_s;
        end else begin
            d_s = m_ext_s;
        end
        n_s = {adiff_s, {QW{1'b0}}};
    end

    sfp_div_core #(
        .NW (NB),
        .DW (DW)
    ) u_div (
        .clk   (clk_in),
        .rst   (rst_in),
        .start (start_s),
        .n     (n_s),
        .d     (d_s),
        .done  (core_done_s),
        .q     (q_s)
    );

    // Result selection: zero-gain limits, or the signed quotient clamped to W bits.
    always_comb begin
        q_neg_s   = -q_s;
        fin_x_s   = {W{1'b0}};
        fin_sat_s = 1'b0;
        if (dz_pend_r) begin
            if (dzero_r) begin
                fin_x_s   = {W{1'b0}};
                fin_sat_s = 1'b0;
            end else begin
                fin_x_s   = dsign_r ? SAT_MIN_X : SAT_MAX_X;
                fin_sat_s = 1'b1;
            end
        end else if (neg_r) begin
            if (q_s > NEG_LIM) begin
                fin_x_s   = SAT_MIN_X;
                fin_sat_s = 1'b1;
            end else begin
                fin_x_s   = q_neg_s[W-1:0];
                fin_sat_s = 1'b0;
            end
        end else begin
            if (q_s > POS_LIM) begin
                fin_x_s   = SAT_MAX_X;
                fin_sat_s = 1'b1;
            end else begin
                fin_x_s   = q_s[W-1:0];
                fin_sat_s = 1'b0;
            end
        end
    end

    // Controller state register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        start_s    = 1'b0;
        finish_s   = 1'b0;
        consume_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (io.in_valid && !rst_in) begin
                    accept_s   = 1'b1;
                    state_nx_s = PREP;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            PREP: begin
                // A zero gain skips the divider but still spends one DIV cycle,
                // giving it a fixed two-edge latency.
                if (m_zero_s) begin
                    start_s = 1'b0;
                end else begin
                    start_s = 1'b1;
                end
                state_nx_s = DIV;
            end
            DIV: begin
                if (dz_pend_r || core_done_s) begin
                    finish_s   = 1'b1;
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = DIV;
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    consume_s  = 1'b1;
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Operand capture, sign bookkeeping and registered result/flags.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            y_r         <= {W{1'b0}};
            m_r         <= {W{1'b0}};
            b_r         <= {W{1'b0}};
            neg_r       <= 1'b0;
            dz_pend_r   <= 1'b0;
            dsign_r     <= 1'b0;
            dzero_r     <= 1'b0;
            x_r         <= {W{1'b0}};
            sat_r       <= 1'b0;
            dz_r        <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                y_r <= io.y;
                m_r <= io.m;
                b_r <= io.b;
            end
            if (state_r == PREP) begin
                neg_r     <= diff_s[W] ^ m_r[W-1];
                dz_pend_r <= m_zero_s;
                dsign_r   <= diff_s[W];
                dzero_r   <= (diff_s == {(W+1){1'b0}});
            end
            if (finish_s) begin
                x_r         <= fin_x_s;
                sat_r       <= fin_sat_s;
                dz_r        <= dz_pend_r;
                out_valid_r <= 1'b1;
            end else if (consume_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign io.in_ready  = (state_r == IDLE) && !rst_in;
    assign io.out_valid = out_valid_r;
    assign io.x         = x_r;
    assign io.sat       = sat_r;
    assign io.dz        = dz_r;

endmodule

// File: tb/tb_affine_solve_seq.sv
// Self-checking bench for affine_solve_seq: vector table, model-driven random
// vectors, backpressure and mid-division reset, all through a result scoreboard.
module tb_affine_solve_seq;

    typedef struct {
        logic [15:0] x;
        logic        sat;
        logic        dz;
    } res_t;

    typedef struct {
        logic [15:0] y;
        logic [15:0] m;
        logic [15:0] b;
        res_t        exp;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    affine_solve_seq_if #(.W(16)) io ();

    affine_solve_seq #(.IW(8), .QW(8)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .io     (io)
    );

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: exact rational arithmetic, truncation toward zero, then clamp.
    function automatic res_t model(input logic [15:0] y, input logic [15:0] m, input logic [15:0] b);
        res_t   r;
        longint diff, num, den, q, s;
        diff = longint'($signed(y)) - longint'($signed(b));
        r.dz = (m == 16'h0000);
        if (r.dz) begin
            if (diff == 0) begin
                r.x   = 16'h0000;
                r.sat = 1'b0;
            end else begin
                r.x   = (diff > 0) ? 16'h7FFF : 16'h8000;
                r.sat = 1'b1;
            end
        end else begin
            num = ((diff < 0) ? -diff : diff) * 256;
            den = longint'($signed(m));
            if (den < 0) den = -den;
            q = num / den;
            s = ((diff < 0) != ($signed(m) < 0)) ? -q : q;
            if (s > 32767) begin
                r.x   = 16'h7FFF;
                r.sat = 1'b1;
            end else if (s < -32768) begin
                r.x   = 16'h8000;
                r.sat = 1'b1;
            end else begin
                r.x   = s[15:0];
                r.sat = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic send(input logic [15:0] y, input logic [15:0] m, input logic [15:0] b, input res_t e);
        io.in_valid = 1'b1;
        io.y = y;
        io.m = m;
        io.b = b;
        check("in_ready before accept", 32'(io.in_ready), 32'd1);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        io.y = 16'($urandom);
        io.m = 16'($urandom);
        io.b = 16'($urandom);
    endtask

    task automatic wait_out(output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end while (!io.out_valid && edges < 200);
        if (!io.out_valid) check("out_valid timeout", 32'd0, 32'd1);
    endtask

    task automatic take(input string name);
        res_t e;
        check({name, " in_ready in DONE"}, 32'(io.in_ready), 32'd0);
        if (exp_q.size() == 0) begin
            check({name, " unexpected output"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({name, " x"}, 32'(io.x), 32'(e.x));
            check({name, " sat"}, 32'(io.sat), 32'(e.sat));
            check({name, " dz"}, 32'(io.dz), 32'(e.dz));
        end
        io.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({name, " out_valid after take"}, 32'(io.out_valid), 32'd0);
        check({name, " in_ready after take"}, 32'(io.in_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   edges;
        int   spurious;
        res_t e;
        logic [15:0] ry, rm, rb;

        vecs[0]  = '{y:16'h0500, m:16'h0200, b:16'h0100, exp:'{x:16'h0200, sat:1'b0, dz:1'b0}, lat:26};
        vecs[1]  = '{y:16'hFD00, m:16'h0200, b:16'h0000, exp:'{x:16'hFE80, sat:1'b0, dz:1'b0}, lat:26};
        vecs[2]  = '{y:16'h0100, m:16'h0300, b:16'h0000, exp:'{x:16'h0055, sat:1'b0, dz:1'b0}, lat:26};
        vecs[3]  = '{y:16'hFF00, m:16'h0300, b:16'h0000, exp:'{x:16'hFFAB, sat:1'b0, dz:1'b0}, lat:26};
        vecs[4]  = '{y:16'h4000, m:16'h8000, b:16'h0000, exp:'{x:16'hFF80, sat:1'b0, dz:1'b0}, lat:26};
        vecs[5]  = '{y:16'h6400, m:16'h0001, b:16'h9C00, exp:'{x:16'h7FFF, sat:1'b1, dz:1'b0}, lat:26};
        vecs[6]  = '{y:16'h6400, m:16'hFFFF, b:16'h9C00, exp:'{x:16'h8000, sat:1'b1, dz:1'b0}, lat:26};
        vecs[7]  = '{y:16'h0100, m:16'h0000, b:16'h0000, exp:'{x:16'h7FFF, sat:1'b1, dz:1'b1}, lat:2};
        vecs[8]  = '{y:16'h0300, m:16'h0000, b:16'h0300, exp:'{x:16'h0000, sat:1'b0, dz:1'b1}, lat:2};
        vecs[9]  = '{y:16'h0000, m:16'h0000, b:16'h0100, exp:'{x:16'h8000, sat:1'b1, dz:1'b1}, lat:2};
        vecs[10] = '{y:16'h8000, m:16'h8000, b:16'h0000, exp:'{x:16'h0100, sat:1'b0, dz:1'b0}, lat:26};
        vecs[11] = '{y:16'h7FFF, m:16'h0100, b:16'h8000, exp:'{x:16'h7FFF, sat:1'b1, dz:1'b0}, lat:26};

        rst          = 1'b1;
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        io.y         = 16'h0000;
        io.m         = 16'h0000;
        io.b         = 16'h0000;

        repeat (3) @(negedge clk);
        check("reset out_valid", 32'(io.out_valid), 32'd0);
        check("reset x", 32'(io.x), 32'd0);
        check("reset sat", 32'(io.sat), 32'd0);
        check("reset dz", 32'(io.dz), 32'd0);
        check("reset in_ready", 32'(io.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("in_ready after reset release", 32'(io.in_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            send(vecs[i].y, vecs[i].m, vecs[i].b, vecs[i].exp);
            wait_out(edges);
            check($sformatf("vec%0d latency", i), 32'(edges), 32'(vecs[i].lat));
            take($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            ry = 16'($urandom);
            rm = (i == 3) ? 16'h0000 : 16'($urandom);
            rb = (i == 5) ? ry : 16'($urandom);
            e  = model(ry, rm, rb);
            send(ry, rm, rb, e);
            wait_out(edges);
            take($sformatf("rand%0d", i));
        end

        // Backpressure: result must hold while new operands are offered and ignored.
        io.out_ready = 1'b0;
        send(vecs[0].y, vecs[0].m, vecs[0].b, vecs[0].exp);
        wait_out(edges);
        for (int c = 0; c < 10; c++) begin
            io.in_valid = 1'b1;
            io.y = 16'($urandom);
            io.m = 16'($urandom);
            io.b = 16'($urandom);
            check("bp out_valid", 32'(io.out_valid), 32'd1);
            check("bp in_ready", 32'(io.in_ready), 32'd0);
            check("bp x stable", 32'(io.x), 32'(vecs[0].exp.x));
            check("bp sat stable", 32'(io.sat), 32'(vecs[0].exp.sat));
            check("bp dz stable", 32'(io.dz), 32'(vecs[0].exp.dz));
            @(posedge clk);
            @(negedge clk);
        end
        io.in_valid = 1'b0;
        take("bp");
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (io.out_valid) spurious++;
        end
        check("bp no extra result", 32'(spurious), 32'd0);

        // Reset in the middle of a division: result is dropped.
        send(vecs[0].y, vecs[0].m, vecs[0].b, vecs[0].exp);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid-div reset out_valid", 32'(io.out_valid), 32'd0);
        check("mid-div reset x", 32'(io.x), 32'd0);
        check("mid-div reset in_ready", 32'(io.in_ready), 32'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (io.out_valid) spurious++;
        end
        check("no stale result after reset", 32'(spurious), 32'd0);
        send(vecs[0].y, vecs[0].m, vecs[0].b, vecs[0].exp);
        wait_out(edges);
        check("post-reset latency", 32'(edges), 32'd26);
        take("post-reset");

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
